wash_seq_ctrl: RTL and testbench

WASH_SEQ_CTRL -- requirements
Module: wash_seq_ctrl

---
 rtl/wash_pkg.sv | 20 ++
 rtl/wash_seq_ctrl_if.sv | 27 ++
 rtl/wash_tick_timer.sv | 21 ++
 rtl/wash_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_wash_seq_ctrl.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/wash_pkg.sv
// wash_pkg: shared state/phase encodings for the wash sequencer
package wash_pkg;
  localparam int STATE_W = 3;
  localparam int PHASE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    S_SHUTDOWN = 3'd0,
    S_BEGIN    = 3'd1,
    S_SET      = 3'd2,
    S_RUN      = 3'd3,
    S_ERROR    = 3'd4,
    S_PAUSE    = 3'd5,
    S_FINISH   = 3'd6
  } state_t;
  typedef enum logic [PHASE_W-1:0] {
    P_IDLE  = 2'd0,
    P_WASH  = 2'd1,
    P_RINSE = 2'd2,
    P_SPIN  = 2'd3
  } phase_t;
endpackage

// File: rtl/wash_seq_ctrl_if.sv
// wash_seq_ctrl_if: panel inputs, program inputs and status outputs of the wash sequencer
interface wash_seq_ctrl_if import wash_pkg::*; #(parameter int TIME_W = 8, parameter int RINSE_MAX = 3);
  localparam int RC_W = $clog2(RINSE_MAX + 1);
  logic              tick;
  logic              powerBtn;
  logic              runBtn;
  logic              openBtn;
  logic              setValid;
  logic [TIME_W-1:0] washTime;
  logic [TIME_W-1:0] rinseTime;
  logic [TIME_W-1:0] spinTime;
  logic [RC_W-1:0]   rinseCnt;
  logic [STATE_W-1:0] state;
  logic [PHASE_W-1:0] phase;
  logic [TIME_W-1:0] remain;
  logic [RC_W-1:0]   rinseLeft;
  logic              done;
  logic              error;
  modport master (
    output tick, powerBtn, runBtn, openBtn, setValid, washTime, rinseTime, spinTime, rinseCnt,
    input  state, phase, remain, rinseLeft, done, error
  );
  modport slave (
    input  tick, powerBtn, runBtn, openBtn, setValid, washTime, rinseTime, spinTime, rinseCnt,
    output state, phase, remain, rinseLeft, done, error
  );
endinterface

// File: rtl/wash_tick_timer.sv
// wash_tick_timer: loadable tick down-counter with clear, hold and terminal flags
module wash_tick_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] remain,
  output logic         last,
  output logic         zero
);
  assign last = remain == W'(1);
  assign zero = remain == '0;
  // clear beats load beats decrement; never wraps below zero
  always_ff @(posedge clk or posedge rst)
    if (rst) remain <= '0;
    else if (clr) remain <= '0;
    else if (load) remain <= load_val;
    else if (dec && !zero) remain <= remain - W'(1);
endmodule

// File: rtl/wash_seq_ctrl.sv
// wash_seq_ctrl: washing machine sequencer; define WASH_SEQ_DOOR_LOCK_EN to trap door-open in RUN as ERROR
module wash_seq_ctrl import wash_pkg::*; #(
  parameter int TIME_W       = 8,
  parameter int RINSE_MAX    = 3,
  parameter int BEGIN_TICKS  = 2,
  parameter int FINISH_TICKS = 3
) (
  input logic           cp,
  input logic           resetBtn,
  wash_seq_ctrl_if.slave bus
);
  localparam int RC_W = $clog2(RINSE_MAX + 1);
`ifdef WASH_SEQ_DOOR_LOCK_EN
  localparam state_t DOOR_ST = S_ERROR;
`else
  localparam state_t DOOR_ST = S_PAUSE;
`endif
  state_t            state_q, state_n;
  phase_t            phase_q, phase_n;
  logic [RC_W-1:0]   rl_q, rl_n, rc_q;
  logic [TIME_W-1:0] wt_q, rt_q, st_q, load_val, remain;
  logic              pv_q, latch, clr_prog, load, dec, clr, last, zero, done_q;
  wash_tick_timer #(.W(TIME_W)) u_tmr (
    .clk(cp), .rst(resetBtn), .clr(clr), .load(load), .load_val(load_val),
    .dec(dec), .remain(remain), .last(last), .zero(zero)
  );
  // state, phase and rinse bookkeeping plus the done/error decodes aligned with state
  always_ff @(posedge cp or posedge resetBtn)
    if (resetBtn) begin
      state_q <= S_SHUTDOWN;
      phase_q <= P_IDLE;
      rl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      rl_q    <= rl_n;
      done_q  <= state_n == S_FINISH;
    end
`ifdef WASH_SEQ_DOOR_LOCK_EN
  logic err_q;
  // error flag tracks the ERROR state in the same cycle
  always_ff @(posedge cp or posedge resetBtn)
    if (resetBtn) err_q <= 1'b0;
    else err_q <= state_n == S_ERROR;
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif
  // program latch: captured only in SET, forgotten at every return to SHUTDOWN
  always_ff @(posedge cp or posedge resetBtn)
    if (resetBtn) begin
      pv_q <= 1'b0;
      wt_q <= '0;
      rt_q <= '0;
      st_q <= '0;
      rc_q <= '0;
    end else if (clr_prog) pv_q <= 1'b0;
    else if (latch) begin
      pv_q <= 1'b1;
      wt_q <= bus.washTime;
      rt_q <= bus.rinseTime;
      st_q <= bus.spinTime;
      rc_q <= (32'(bus.rinseCnt) > RINSE_MAX) ? RC_W'(RINSE_MAX) : bus.rinseCnt;
    end
  // next state, phase sequencing and timer control; power loss overrides everything
  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    rl_n     = rl_q;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    clr      = 1'b0;
    latch    = 1'b0;
    clr_prog = 1'b0;
    if (state_q != S_SHUTDOWN && !bus.powerBtn) begin
      state_n  = S_SHUTDOWN;
      phase_n  = P_IDLE;
      rl_n     = '0;
      clr      = 1'b1;
      clr_prog = 1'b1;
    end else
      case (state_q)
        S_SHUTDOWN: if (bus.powerBtn) begin
          state_n  = S_BEGIN;
          load     = 1'b1;
          load_val = TIME_W'(BEGIN_TICKS);
        end
        S_BEGIN: begin
          dec = bus.tick;
          if (zero || (bus.tick && last)) state_n = S_SET;
        end
        S_SET: begin
          latch = bus.setValid;
          if (bus.runBtn && !bus.openBtn && pv_q) begin
            state_n  = S_RUN;
            phase_n  = P_WASH;
            rl_n     = rc_q;
            load     = 1'b1;
            load_val = wt_q;
          end
        end
        S_RUN:
          if (bus.openBtn) state_n = DOOR_ST;
          else if (!bus.runBtn) state_n = S_PAUSE;
          else begin
            dec = bus.tick;
            if (zero || (bus.tick && last)) begin
              load = 1'b1;
              case (phase_q)
                P_WASH: begin
                  phase_n  = rl_q != '0 ? P_RINSE : P_SPIN;
                  load_val = rl_q != '0 ? rt_q : st_q;
                end
                P_RINSE: begin
                  phase_n  = rl_q > RC_W'(1) ? P_RINSE : P_SPIN;
                  load_val = rl_q > RC_W'(1) ? rt_q : st_q;
                  rl_n     = rl_q > RC_W'(1) ? rl_q - RC_W'(1) : '0;
                end
                default: begin
                  state_n  = S_FINISH;
                  phase_n  = P_IDLE;
                  load_val = TIME_W'(FINISH_TICKS);
                end
              endcase
            end
          end
        S_PAUSE: if (bus.runBtn && !bus.openBtn) state_n = S_RUN;
`ifdef WASH_SEQ_DOOR_LOCK_EN
        S_ERROR: if (!bus.openBtn && !bus.runBtn) state_n = S_PAUSE;
`endif
        S_FINISH: begin
          dec = bus.tick;
          if (zero || (bus.tick && last)) begin
            state_n  = S_SHUTDOWN;
            clr_prog = 1'b1;
          end
        end
        default: begin
          state_n = S_SHUTDOWN;
          phase_n = P_IDLE;
          rl_n    = '0;
          clr     = 1'b1;
        end
      endcase
  end
  assign bus.state     = state_q;
  assign bus.phase     = phase_q;
  assign bus.remain    = remain;
  assign bus.rinseLeft = rl_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_wash_seq_ctrl.sv
// tb_wash_seq_ctrl: scoreboard bench for wash_seq_ctrl (default parameters)
module tb_wash_seq_ctrl;
  logic cp = 1'b0;
  logic resetBtn = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  string tag_q[$];
`ifdef WASH_SEQ_DOOR_LOCK_EN
  localparam int DOOR = 4;
`else
  localparam int DOOR = 5;
`endif
  wash_seq_ctrl_if #(.TIME_W(8), .RINSE_MAX(3)) bus();
  wash_seq_ctrl #(.TIME_W(8), .RINSE_MAX(3), .BEGIN_TICKS(2), .FINISH_TICKS(3)) dut (
    .cp(cp), .resetBtn(resetBtn), .bus(bus)
  );
  always #5 cp = ~cp;
  function automatic logic [16:0] e(input int st, input int ph, input int rem, input int rl);
    return {3'(st), 2'(ph), 8'(rem), 2'(rl), st == 6, st == 4};
  endfunction
  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d ph=%0d rem=%0d rl=%0d done=%b err=%b, want st=%0d ph=%0d rem=%0d rl=%0d done=%b err=%b",
               tag, got[16:14], got[13:12], got[11:4], got[3:2], got[1], got[0],
               exp[16:14], exp[13:12], exp[11:4], exp[3:2], exp[1], exp[0]);
    end
  endtask
  task automatic push(input string tag, input logic [16:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask
  task automatic pop_check();
    chk(tag_q.pop_front(), {bus.state, bus.phase, bus.remain, bus.rinseLeft, bus.done, bus.error}, exp_q.pop_front());
  endtask
  task automatic cyc(input bit tk, input logic [16:0] exp, input string tag);
    bus.tick = tk;
    push(tag, exp);
    @(posedge cp);
    #1;
    bus.tick = 1'b0;
    pop_check();
  endtask
  task automatic prog(input int w, input int rc, input int r, input int s);
    bus.washTime  = 8'(w);
    bus.rinseCnt  = 2'(rc);
    bus.rinseTime = 8'(r);
    bus.spinTime  = 8'(s);
  endtask
  initial begin
    bus.tick = 0; bus.powerBtn = 0; bus.runBtn = 0; bus.openBtn = 0; bus.setValid = 0;
    prog(0, 0, 0, 0);
    @(posedge cp); #1;
    push("reset", e(0, 0, 0, 0));
    pop_check();
    resetBtn = 1'b0;
    cyc(0, e(0, 0, 0, 0), "off_idle");
    bus.powerBtn = 1;
    cyc(0, e(1, 0, 2, 0), "pwr_begin");
    cyc(1, e(1, 0, 1, 0), "begin_t1");
    cyc(0, e(1, 0, 1, 0), "begin_hold");
    cyc(1, e(2, 0, 0, 0), "begin_set");
    prog(3, 2, 2, 1);
    bus.setValid = 1;
    cyc(0, e(2, 0, 0, 0), "set_latch");
    bus.setValid = 0;
    bus.runBtn = 1;
    cyc(0, e(3, 1, 3, 2), "run_wash");
    cyc(1, e(3, 1, 2, 2), "wash_2");
    cyc(1, e(3, 1, 1, 2), "wash_1");
    cyc(1, e(3, 2, 2, 2), "rinse1_2");
    cyc(1, e(3, 2, 1, 2), "rinse1_1");
    cyc(1, e(3, 2, 2, 1), "rinse2_2");
    cyc(1, e(3, 2, 1, 1), "rinse2_1");
    cyc(1, e(3, 3, 1, 0), "spin_1");
    cyc(1, e(6, 0, 3, 0), "finish_3");
    cyc(1, e(6, 0, 2, 0), "finish_2");
    cyc(1, e(6, 0, 1, 0), "finish_1");
    cyc(1, e(0, 0, 0, 0), "finish_off");
    cyc(0, e(1, 0, 2, 0), "repower");
    cyc(1, e(1, 0, 1, 0), "rebegin");
    cyc(1, e(2, 0, 0, 0), "reset_set");
    cyc(0, e(2, 0, 0, 0), "no_prog");
    prog(3, 0, 5, 1);
    bus.setValid = 1;
    cyc(0, e(2, 0, 0, 0), "latch2");
    bus.setValid = 0;
    cyc(0, e(3, 1, 3, 0), "run2");
    cyc(1, e(3, 1, 2, 0), "wash2_2");
    bus.runBtn = 0;
    cyc(0, e(5, 1, 2, 0), "pause");
    for (int i = 0; i < 5; i++) cyc(1, e(5, 1, 2, 0), "pause_hold");
    bus.runBtn = 1;
    cyc(0, e(3, 1, 2, 0), "resume");
    cyc(1, e(3, 1, 1, 0), "resume_1");
    cyc(1, e(3, 3, 1, 0), "skip_rinse");
    bus.openBtn = 1;
    cyc(0, e(DOOR, 3, 1, 0), "door");
    cyc(1, e(DOOR, 3, 1, 0), "door_hold");
    bus.openBtn = 0;
    bus.runBtn = 0;
    cyc(0, e(5, 3, 1, 0), "door_pause");
    bus.openBtn = 1;
    bus.runBtn = 1;
    cyc(0, e(5, 3, 1, 0), "pause_open");
    bus.openBtn = 0;
    cyc(0, e(3, 3, 1, 0), "door_resume");
    bus.powerBtn = 0;
    cyc(1, e(0, 0, 0, 0), "pwroff_spin");
    bus.powerBtn = 1;
    cyc(0, e(1, 0, 2, 0), "pwr3");
    cyc(1, e(1, 0, 1, 0), "begin3");
    cyc(1, e(2, 0, 0, 0), "set3");
    prog(0, 0, 4, 2);
    bus.setValid = 1;
    cyc(0, e(2, 0, 0, 0), "latch3");
    bus.setValid = 0;
    cyc(0, e(3, 1, 0, 0), "zero_wash");
    cyc(0, e(3, 3, 2, 0), "zero_skip");
    bus.powerBtn = 0;
    cyc(0, e(0, 0, 0, 0), "pwroff3");
    bus.powerBtn = 1;
    cyc(0, e(1, 0, 2, 0), "pwr4");
    cyc(1, e(1, 0, 1, 0), "begin4");
    cyc(1, e(2, 0, 0, 0), "set4");
    prog(1, 1, 3, 1);
    bus.setValid = 1;
    cyc(0, e(2, 0, 0, 0), "latch4");
    bus.setValid = 0;
    cyc(0, e(3, 1, 1, 1), "run4");
    cyc(1, e(3, 2, 3, 1), "rinse4_3");
    cyc(1, e(3, 2, 2, 1), "rinse4_2");
    #2 resetBtn = 1'b1;
    #1;
    push("async_rst", e(0, 0, 0, 0));
    pop_check();
    bus.powerBtn = 0;
    @(posedge cp); #1;
    resetBtn = 1'b0;
    cyc(0, e(0, 0, 0, 0), "post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
